// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a fixed codec register table through the I2C write engine,
// one frame per word, with NACK/timeout retries and an inter-frame gap.
module i2c_config_sequencer #(
  parameter int NUM_REGS       = 10,
  parameter int GAP_CYCLES     = 50000,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        irstn,
  input  logic        start,
  input  logic        i2c_finish,
  input  logic [2:0]  i2c_ack,
  output logic        i2c_ignition,
  output logic [15:0] i2c_word,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  reg_index
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, GAP, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [15:0] word_q, word_d, rom_word;
  logic [3:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic armed_q, armed_d, tout_q, tout_d, done_q, done_d, error_q, error_d;
  logic fin_hit, tmo_hit, gap_end, ack_ok, accept, retry_left;
  always_comb begin
    case (idx_q)
      4'd0:    rom_word = 16'h1E00;
      4'd1:    rom_word = 16'h0C00;
      4'd2:    rom_word = 16'h0812;
      4'd3:    rom_word = 16'h0A00;
      4'd4:    rom_word = 16'h0E42;
      4'd5:    rom_word = 16'h1000;
      4'd6:    rom_word = 16'h0017;
      4'd7:    rom_word = 16'h0217;
      4'd8:    rom_word = 16'h0479;
      4'd9:    rom_word = 16'h0679;
      default: rom_word = 16'h0000;
    endcase
  end
  // A finish level is only taken as completion once it has been seen low in this frame.
  assign fin_hit    = armed_q && i2c_finish;
  assign tmo_hit    = int'(tmo_q) == TIMEOUT_CYCLES - 1;
  assign gap_end    = int'(gap_q) == GAP_CYCLES - 1;
  assign ack_ok     = i2c_ack == 3'b111 && !tout_q;
  assign accept     = state_q == IDLE && start;
  assign retry_left = int'(retry_q) < MAX_RETRY;
  always_ff @(posedge clk) begin
    if (!irstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      armed_q <= 1'b0;
      tout_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      armed_q <= armed_d;
      tout_q  <= tout_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = (fin_hit || tmo_hit) ? CHECK : RUN;
      CHECK:   state_d = (ack_ok || retry_left) ? GAP : ERROR;
      GAP:     state_d = !gap_end ? GAP : idx_q == 4'(NUM_REGS) ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    word_d  = state_q == LOAD ? rom_word : word_q;
    armed_d = state_q == RUN && (armed_q || !i2c_finish);
    tout_d  = state_q == RUN ? tmo_hit && !fin_hit : tout_q;
    tmo_d   = state_q == RUN ? tmo_q + TW'(1) : '0;
    gap_d   = state_q == GAP ? gap_q + GW'(1) : '0;
    retry_d = (accept || (state_q == CHECK && ack_ok)) ? '0 :
              (state_q == CHECK && retry_left) ? retry_q + RW'(1) : retry_q;
    idx_d   = accept ? '0 :
              (state_q == CHECK && ack_ok) ? idx_q + 4'd1 :
              state_d == DONE ? 4'(NUM_REGS - 1) : idx_q;
    done_d  = accept ? 1'b0 : state_d == DONE ? 1'b1 : done_q;
    error_d = accept ? 1'b0 : state_d == ERROR ? 1'b1 : error_q;
  end
  always_comb begin
    i2c_ignition = state_q == RUN;
    busy         = state_q inside {LOAD, RUN, CHECK, GAP};
    i2c_word     = word_q;
    done         = done_q;
    error        = error_q;
    reg_index    = idx_q;
  end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: randomized engine model plus a frame-level reference of the
// configuration pass (expected word order, frame timing, final status).
module tb_i2c_config_sequencer;
  localparam int NR = 10, GAP = 20, MR = 3, TMO = 500;
  localparam logic [15:0] TBL [16] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E42,
    16'h1000, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic clk = 1'b0, irstn = 1'b0, start = 1'b0, i2c_finish = 1'b1;
  logic [2:0] i2c_ack = 3'b111;
  logic i2c_ignition, busy, done, error;
  logic [15:0] i2c_word;
  logic [3:0] reg_index;
  int total = 0, bad = 0;
  logic [2:0] p_ack[$];
  bit p_hang[$];
  logic [15:0] e_word[$];
  bit e_done, e_err;
  int e_idx;

  i2c_config_sequencer #(.NUM_REGS(NR), .GAP_CYCLES(GAP), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .irstn(irstn), .start(start), .i2c_finish(i2c_finish), .i2c_ack(i2c_ack),
    .i2c_ignition(i2c_ignition), .i2c_word(i2c_word), .busy(busy), .done(done),
    .error(error), .reg_index(reg_index));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each frame's outcome decides the next word; retries and error follow the rules.
  task automatic build_plan(input int mode);
    int idx = 0, a = 0;
    logic [2:0] ack;
    bit hang;
    p_ack.delete(); p_hang.delete(); e_word.delete();
    while (1) begin
      ack = 3'b111; hang = 1'b0;
      case (mode)
        1: if (idx == 4 && a == 0) ack = 3'b101;
        2: if (idx == 2) ack = 3'b011;
        3: if (idx == 0) hang = 1'b1;
        4: begin
          if ($urandom_range(0, 5) == 0) ack = 3'($urandom_range(0, 6));
          hang = $urandom_range(0, 29) == 0;
        end
        default: ;
      endcase
      p_ack.push_back(ack); p_hang.push_back(hang); e_word.push_back(TBL[idx]);
      if (ack == 3'b111 && !hang) begin
        idx++; a = 0;
        if (idx == NR) begin e_done = 1; e_err = 0; e_idx = NR - 1; return; end
      end else begin
        a++;
        if (a > MR) begin e_done = 0; e_err = 1; e_idx = idx; return; end
      end
    end
  endtask

  task automatic run_pass(input int mode, input bit extra, input int rst_frame);
    int cyc, frames = 0, hicnt = 0, locnt = 0, stale = 0, low = 0;
    bit hang = 0, prev = 0;
    build_plan(mode);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (1) begin
      if (i2c_ignition && !prev) begin
        if (frames == 0) chk("latency", cyc, 2); else chk("gap_len", locnt, GAP + 2);
        if (frames < e_word.size()) begin
          chk("word", i2c_word, e_word[frames]);
          i2c_ack = p_ack[frames]; hang = p_hang[frames];
        end else begin
          chk("frame_count", frames + 1, e_word.size()); hang = 0;
        end
        stale = $urandom_range(0, 6); low = $urandom_range(20, 150); hicnt = 0; frames++;
      end
      if (!i2c_ignition && prev) chk("high_len", hicnt, hang ? TMO : stale + low + 1);
      if (i2c_ignition) begin
        hicnt++; locnt = 0;
        i2c_finish = hicnt <= stale ? 1'b1 : (hang || hicnt <= stale + low) ? 1'b0 : 1'b1;
      end else locnt++;
      if (rst_frame > 0 && frames == rst_frame && i2c_ignition && hicnt == 10) begin
        irstn = 1'b0;
        @(negedge clk);
        chk("rst_ign", i2c_ignition, 0); chk("rst_busy", busy, 0); chk("rst_idx", reg_index, 0);
        irstn = 1'b1;
        return;
      end
      if (!busy) break;
      if (cyc > 20000) begin chk("pass_budget", cyc, 20000); break; end
      prev = i2c_ignition;
      @(negedge clk); cyc++;
      start = extra && busy && $urandom_range(0, 39) == 0;
    end
    start = 1'b0;
    chk("done", done, e_done); chk("error", error, e_err); chk("reg_index", reg_index, e_idx);
    chk("ign_end", i2c_ignition, 0); chk("frames", frames, e_word.size());
    @(negedge clk);
    chk("busy_idle", busy, 0); chk("done_sticky", done, e_done); chk("error_sticky", error, e_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ignition", i2c_ignition, 0); chk("rst_word", i2c_word, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_error", error, 0); chk("rst_index", reg_index, 0);
    irstn = 1'b1;
    run_pass(0, 0, -1);
    run_pass(1, 1, -1);
    run_pass(2, 0, -1);
    run_pass(3, 0, -1);
    run_pass(0, 1, 6);
    run_pass(0, 0, -1);
    for (int i = 0; i < 8; i++) run_pass(4, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
